// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and helpers for the display pixel buffer
package disp_pkg;
  localparam int R_OFS     = 16;
  localparam int G_OFS     = 8;
  localparam int B_OFS     = 0;
  localparam int PIX_W_DEF = 24;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/disp_pixbuf_sc_if.sv
// disp_pixbuf_sc_if: DMA write side, timing-generator side and status of the pixel buffer
interface disp_pixbuf_sc_if import disp_pkg::*; #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 512,
  localparam int CW    = cnt_w(DEPTH)
);
  logic              DISPON, FIFORST, FIFOWR, DSP_preDE;
  logic [DATA_W-1:0] FIFOIN;
  logic              BUF_WREADY, BUF_OVER, BUF_UNDER, DSP_DE;
  logic [7:0]        DSP_R, DSP_G, DSP_B;
  logic [CW-1:0]     WCOUNT;
  modport master(output DISPON, FIFORST, FIFOWR, DSP_preDE, FIFOIN,
                 input BUF_WREADY, BUF_OVER, BUF_UNDER, DSP_DE, DSP_R, DSP_G, DSP_B, WCOUNT);
  modport slave(input DISPON, FIFORST, FIFOWR, DSP_preDE, FIFOIN,
                output BUF_WREADY, BUF_OVER, BUF_UNDER, DSP_DE, DSP_R, DSP_G, DSP_B, WCOUNT);
endinterface

// File: rtl/disp_sc_fifo.sv
// disp_sc_fifo: single-clock first-word-fall-through FIFO with occupancy count
module disp_sc_fifo import disp_pkg::*; #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 512,
  localparam int CW    = cnt_w(DEPTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic [CW-1:0]     count
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic              wr_ok, rd_ok;
  assign wr_ok = wr & ~full;
  assign rd_ok = rd & ~empty;
  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
  assign head  = mem[rptr];
  always_ff @(posedge clk)
    if (wr_ok && !clr) mem[wptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(wr_ok);
      rptr  <= rptr + AW'(rd_ok);
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
endmodule

// File: rtl/disp_pixbuf_sc.sv
// disp_pixbuf_sc: display pixel buffer that stages FIFO words and unpacks them into paced RGB pixels
module disp_pixbuf_sc import disp_pkg::*; #(
  parameter int DATA_W = 64,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int PPW    = 2,
  parameter int DEPTH  = 512,
  parameter int BURST  = 16,
  localparam int CW    = cnt_w(DEPTH),
  localparam int IW    = PPW > 1 ? $clog2(PPW) : 1
) (
  input logic              ACLK,
  input logic              ARSTN,
  disp_pixbuf_sc_if.slave  bus
);
  logic [DATA_W-1:0] head, cur;
  logic              cur_v, empty, full, consume, take, last, load;
  logic [IW-1:0]     idx;
  logic [CW-1:0]     count, count_nxt;
  logic [PIX_W-1:0]  pix;
  assign consume   = bus.DSP_preDE & bus.DISPON;
  assign take      = consume & cur_v & ~bus.FIFORST;
  assign last      = take & (idx == IW'(PPW - 1));
  assign load      = (~cur_v | last) & ~empty & bus.DISPON & ~bus.FIFORST;
  assign pix       = cur[idx*PIX_W +: PIX_W];
  assign count_nxt = count + CW'(bus.FIFOWR & ~full) - CW'(load);
  assign bus.WCOUNT = count;
  disp_sc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(ACLK), .rst_n(ARSTN), .clr(bus.FIFORST), .wr(bus.FIFOWR), .rd(load),
    .din(bus.FIFOIN), .head(head), .empty(empty), .full(full), .count(count)
  );
  always_ff @(posedge ACLK or negedge ARSTN)
    if (!ARSTN) begin
      bus.DSP_DE     <= 1'b0;
      bus.DSP_R      <= '0;
      bus.DSP_G      <= '0;
      bus.DSP_B      <= '0;
      bus.BUF_WREADY <= 1'b0;
      bus.BUF_OVER   <= 1'b0;
      bus.BUF_UNDER  <= 1'b0;
      cur            <= '0;
      cur_v          <= 1'b0;
      idx            <= '0;
    end else begin
      bus.DSP_DE     <= consume;
      bus.DSP_R      <= take ? pix[R_OFS +: 8] : '0;
      bus.DSP_G      <= take ? pix[G_OFS +: 8] : '0;
      bus.DSP_B      <= take ? pix[B_OFS +: 8] : '0;
      bus.BUF_WREADY <= ~bus.FIFORST & (count_nxt <= CW'(DEPTH - BURST));
      bus.BUF_OVER   <= ~bus.FIFORST & (bus.BUF_OVER | (bus.FIFOWR & full));
      bus.BUF_UNDER  <= ~bus.FIFORST & (bus.BUF_UNDER | (consume & ~cur_v));
      cur            <= load ? head : cur;
      cur_v          <= ~bus.FIFORST & (load | (cur_v & ~last));
      idx            <= (bus.FIFORST | last) ? '0 : take ? idx + 1'b1 : idx;
    end
endmodule

// File: tb/tb_disp_pixbuf_sc.sv
// tb_disp_pixbuf_sc: randomized self-checking bench against a queue-based pixel buffer model
module tb_disp_pixbuf_sc;
  localparam int DATA_W = 64, PPW = 2, DEPTH = 512, BURST = 16, CW = 10;
  logic ACLK = 1'b0;
  logic ARSTN = 1'b0;
  always #5 ACLK = ~ACLK;
  disp_pixbuf_sc_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus();
  disp_pixbuf_sc #(.DATA_W(DATA_W), .PPW(PPW), .DEPTH(DEPTH), .BURST(BURST)) dut (
    .ACLK(ACLK), .ARSTN(ARSTN), .bus(bus.slave)
  );
  int total = 0, bad = 0;
  logic [63:0] mq[$];
  logic [23:0] sp[$];
  logic        m_over, m_under, m_de, m_wready;
  logic [23:0] m_rgb;
  wire  [23:0] rgb = {bus.DSP_R, bus.DSP_G, bus.DSP_B};
  wire  [37:0] obs = {bus.DSP_DE, rgb, bus.WCOUNT, bus.BUF_OVER, bus.BUF_UNDER, bus.BUF_WREADY};
  logic [37:0] exp_v;

  always_comb exp_v = {m_de, m_rgb, CW'(mq.size()), m_over, m_under, m_wready};

  task automatic model_clear();
    mq.delete(); sp.delete();
    m_over = 0; m_under = 0; m_de = 0; m_wready = 0; m_rgb = 0;
  endtask

  task automatic step(input logic wr, input logic [63:0] d, input logic pre, input logic on, input logic clr);
    logic full_pre;
    logic [63:0] w;
    bus.FIFOWR = wr; bus.FIFOIN = d; bus.DSP_preDE = pre; bus.DISPON = on; bus.FIFORST = clr;
    @(posedge ACLK);
    m_de = pre & on;
    m_rgb = 0;
    if (clr) begin
      mq.delete(); sp.delete();
      m_over = 0; m_under = 0; m_wready = 0;
    end else begin
      full_pre = mq.size() == DEPTH;
      if (pre && on) begin
        if (sp.size() > 0) m_rgb = sp.pop_front();
        else m_under = 1;
      end
      if (on && sp.size() == 0 && mq.size() > 0) begin
        w = mq.pop_front();
        for (int k = 0; k < PPW; k++) sp.push_back(w[k*24 +: 24]);
      end
      if (wr) begin
        if (full_pre) m_over = 1;
        else mq.push_back(d);
      end
      m_wready = (DEPTH - mq.size()) >= BURST;
    end
    #1;
  endtask

  task automatic do_reset();
    bus.FIFOWR = 0; bus.FIFOIN = 0; bus.DSP_preDE = 0; bus.DISPON = 0; bus.FIFORST = 0;
    ARSTN = 0;
    model_clear();
    repeat (2) @(posedge ACLK);
    #1 ARSTN = 1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (obs !== 38'h0) begin bad++; $display("FAIL reset_state got=%h exp=0", obs); end
    step(0, 0, 0, 1, 0);
    total++;
    if (bus.BUF_WREADY !== 1'b1 || bus.WCOUNT !== '0) begin
      bad++; $display("FAIL reset_wready got=%b/%0d exp=1/0", bus.BUF_WREADY, bus.WCOUNT);
    end
  endtask

  task automatic test_basic();
    do_reset();
    repeat (4) step(1, {16'h0, 24'h332211, 24'hCCBBAA}, 0, 1, 0);
    total++;
    if (bus.DSP_DE !== 1'b0) begin bad++; $display("FAIL basic_de_idle got=%b exp=0", bus.DSP_DE); end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 1, 0);
      total++;
      if (bus.DSP_DE !== 1'b1 || rgb !== ((i % 2) ? 24'h332211 : 24'hCCBBAA) || bus.BUF_UNDER !== 1'b0) begin
        bad++; $display("FAIL basic_pix%0d got=%b/%h/%b exp=1/%h/0", i, bus.DSP_DE, rgb, bus.BUF_UNDER,
                        (i % 2) ? 24'h332211 : 24'hCCBBAA);
      end
    end
    step(0, 0, 0, 1, 0);
    total++;
    if (bus.DSP_DE !== 1'b0 || rgb !== 24'h0) begin
      bad++; $display("FAIL basic_tail got=%b/%h exp=0/000000", bus.DSP_DE, rgb);
    end
  endtask

  task automatic test_underflow();
    step(0, 0, 1, 1, 0);
    total++;
    if (bus.DSP_DE !== 1'b1 || rgb !== 24'h0 || bus.BUF_UNDER !== 1'b1) begin
      bad++; $display("FAIL under_set got=%b/%h/%b exp=1/000000/1", bus.DSP_DE, rgb, bus.BUF_UNDER);
    end
    repeat (3) step(0, 0, 0, 1, 0);
    total++;
    if (bus.BUF_UNDER !== 1'b1) begin bad++; $display("FAIL under_sticky got=%b exp=1", bus.BUF_UNDER); end
    step(0, 0, 0, 1, 1);
    total++;
    if (bus.BUF_UNDER !== 1'b0) begin bad++; $display("FAIL under_clear got=%b exp=0", bus.BUF_UNDER); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 497; i++) begin
      step(1, {$urandom, $urandom}, 0, 0, 0);
      if (i == 495) begin
        total++;
        if (bus.BUF_WREADY !== 1'b1) begin bad++; $display("FAIL fill_free16 got=%b exp=1", bus.BUF_WREADY); end
      end
    end
    total++;
    if (bus.BUF_WREADY !== 1'b0 || bus.WCOUNT !== 10'd497) begin
      bad++; $display("FAIL fill_free15 got=%b/%0d exp=0/497", bus.BUF_WREADY, bus.WCOUNT);
    end
    step(0, 0, 0, 1, 0);
    total++;
    if (bus.BUF_WREADY !== 1'b1 || bus.WCOUNT !== 10'd496) begin
      bad++; $display("FAIL fill_pop got=%b/%0d exp=1/496", bus.BUF_WREADY, bus.WCOUNT);
    end
    repeat (16) step(1, {$urandom, $urandom}, 0, 0, 0);
    total++;
    if (bus.WCOUNT !== 10'd512 || bus.BUF_OVER !== 1'b0) begin
      bad++; $display("FAIL fill_full got=%0d/%b exp=512/0", bus.WCOUNT, bus.BUF_OVER);
    end
    step(1, 64'hDEAD, 0, 0, 0);
    total++;
    if (bus.WCOUNT !== 10'd512 || bus.BUF_OVER !== 1'b1) begin
      bad++; $display("FAIL fill_over got=%0d/%b exp=512/1", bus.WCOUNT, bus.BUF_OVER);
    end
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL fill_model got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_stream();
    do_reset();
    repeat (11) step(1, {$urandom, $urandom}, 0, 1, 0);
    total++;
    if (bus.WCOUNT !== 10'd10) begin bad++; $display("FAIL stream_setup got=%0d exp=10", bus.WCOUNT); end
    for (int i = 0; i < 100; i++) begin
      step(sp.size() == 1, {$urandom, $urandom}, 1, 1, 0);
      total++;
      if (obs !== exp_v || bus.WCOUNT !== 10'd10) begin
        bad++; $display("FAIL stream cyc=%0d got=%h exp=%h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 6, {$urandom, $urandom}, $urandom_range(0, 1),
           $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0);
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, exp_v); end
    end
  endtask

  task automatic test_fiforst_mid();
    do_reset();
    step(0, 0, 1, 1, 0);
    repeat (3) step(1, {$urandom, $urandom}, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    step(1, 64'h1234_5678_9ABC_DEF0, 1, 1, 1);
    total++;
    if (bus.WCOUNT !== '0 || bus.BUF_OVER !== 1'b0 || bus.BUF_UNDER !== 1'b0 || bus.DSP_DE !== 1'b1 ||
        rgb !== 24'h0 || bus.BUF_WREADY !== 1'b0) begin
      bad++; $display("FAIL fiforst_clear got=%h exp=%h", obs, {1'b1, 24'h0, 10'd0, 3'b000});
    end
    step(1, {16'h0, 24'h665544, 24'h112233}, 0, 1, 0);
    total++;
    if (bus.WCOUNT !== 10'd1) begin bad++; $display("FAIL fiforst_write got=%0d exp=1", bus.WCOUNT); end
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    total++;
    if (rgb !== 24'h112233 || bus.WCOUNT !== '0) begin
      bad++; $display("FAIL fiforst_pix0 got=%h/%0d exp=112233/0", rgb, bus.WCOUNT);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (6) step(1, {$urandom, $urandom}, 0, 1, 0);
    step(1, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    total++;
    if (bus.DSP_DE !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b exp=1", bus.DSP_DE); end
    #2 ARSTN = 0;
    #1;
    total++;
    if (obs !== 38'h0) begin bad++; $display("FAIL arst_async got=%h exp=0", obs); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_fill();
    test_stream();
    test_random();
    test_fiforst_mid();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
